// File: rtl/lt8_sort_ctrl.sv
// Batch byte sorter: loads DEPTH bytes, bubble-sorts them in place using one
// external less-than comparator per cycle (early exit), then streams them out.
module lt8_sort_ctrl #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic [7:0]       cmp_a,
   output logic [7:0]       cmp_b,
   input  logic             cmp_lt,
   output logic             busy,
   output logic [CNT_W-1:0] sort_cycles
);

   localparam int unsigned IdxW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);
   localparam logic [IdxW-1:0] LastJ0  = IdxW'(DEPTH - 2);

   typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

   state_e           state_q, state_d;
   logic [7:0]       mem_q [DEPTH];
   logic [7:0]       mem_d [DEPTH];
   logic [IdxW-1:0]  load_idx_q, load_idx_d;
   logic [IdxW-1:0]  drain_idx_q, drain_idx_d;
   logic [IdxW-1:0]  pass_q, pass_d;
   logic [IdxW-1:0]  j_q, j_d;
   logic             swapped_q, swapped_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IdxW-1:0]  j_next;
   logic [IdxW-1:0]  last_j;
   logic             swapped_now;

   assign j_next = j_q + IdxW'(1);
   // Each pass bubbles the largest remaining byte to the top, shrinking the range.
   assign last_j = LastJ0 - pass_q;

   // Outputs decoded from state; comparator operands idle at zero outside SORT.
   always_comb begin
      in_ready    = (state_q == StLoad);
      out_valid   = (state_q == StDrain);
      busy        = (state_q != StLoad);
      out_data    = (state_q == StDrain) ? mem_q[drain_idx_q] : 8'd0;
      cmp_a       = (state_q == StSort) ? mem_q[j_next] : 8'd0;
      cmp_b       = (state_q == StSort) ? mem_q[j_q] : 8'd0;
      sort_cycles = cnt_q;
   end

   // Next-state logic for load, compare/swap and drain sequencing.
   always_comb begin
      state_d     = state_q;
      mem_d       = mem_q;
      load_idx_d  = load_idx_q;
      drain_idx_d = drain_idx_q;
      pass_d      = pass_q;
      j_d         = j_q;
      swapped_d   = swapped_q;
      cnt_d       = cnt_q;
      swapped_now = swapped_q;
      case (state_q)
         StLoad: begin
            if (in_valid) begin
               mem_d[load_idx_q] = in_data;
               if (load_idx_q == LastIdx) begin
                  load_idx_d = '0;
                  state_d    = StSort;
                  cnt_d      = '0;
                  pass_d     = '0;
                  j_d        = '0;
                  swapped_d  = 1'b0;
               end else begin
                  load_idx_d = load_idx_q + IdxW'(1);
               end
            end
         end
         StSort: begin
            cnt_d = cnt_q + CNT_W'(1);
            // Strict less-than keeps equal bytes in order (stable sort).
            if (cmp_lt) begin
               mem_d[j_q]    = mem_q[j_next];
               mem_d[j_next] = mem_q[j_q];
               swapped_now   = 1'b1;
            end
            if (j_q == last_j) begin
               if (!swapped_now || last_j == '0) begin
                  state_d = StDrain;
               end else begin
                  pass_d    = pass_q + IdxW'(1);
                  j_d       = '0;
                  swapped_d = 1'b0;
               end
            end else begin
               j_d       = j_next;
               swapped_d = swapped_now;
            end
         end
         StDrain: begin
            if (out_ready) begin
               if (drain_idx_q == LastIdx) begin
                  drain_idx_d = '0;
                  state_d     = StLoad;
               end else begin
                  drain_idx_d = drain_idx_q + IdxW'(1);
               end
            end
         end
         default: state_d = StLoad;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StLoad;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'd0;
         load_idx_q  <= '0;
         drain_idx_q <= '0;
         pass_q      <= '0;
         j_q         <= '0;
         swapped_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         load_idx_q  <= load_idx_d;
         drain_idx_q <= drain_idx_d;
         pass_q      <= pass_d;
         j_q         <= j_d;
         swapped_q   <= swapped_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_lt8_sort_ctrl.sv
// Bench for lt8_sort_ctrl: table of batches plus hand-written stall, reset
// and ignored-input sequences. The comparator is modelled beside the DUT.
module tb_lt8_sort_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [7:0] cmp_a;
   logic [7:0] cmp_b;
   logic       cmp_lt;
   logic       busy;
   logic [5:0] sort_cycles;

   int errors = 0;
   int checks = 0;
   int tr_a [40];
   int tr_b [40];

   always #5 clk = ~clk;

   assign cmp_lt = (cmp_a < cmp_b);

   lt8_sort_ctrl #(.DEPTH(4), .CNT_W(6)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .cmp_a       (cmp_a),
      .cmp_b       (cmp_b),
      .cmp_lt      (cmp_lt),
      .busy        (busy),
      .sort_cycles (sort_cycles)
   );

   typedef struct {
      logic [0:3][7:0] din;
      logic [0:3][7:0] dout;
      int              cyc;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Presents four bytes with in_valid held; returns at the first SORT negedge.
   task automatic load(input logic [0:3][7:0] d, input logic hold99);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("load_in_ready", in_ready, 1);
         in_valid = 1'b1;
         in_data  = d[i];
      end
      @(negedge clk);
      in_valid = hold99;
      in_data  = 8'd99;
      chk("sort_in_ready", in_ready, 0);
      chk("sort_busy", busy, 1);
   endtask

   task automatic run_sort(input int exp_cyc);
      int n = 0;
      while (busy && !out_valid && n < 40) begin
         tr_a[n] = cmp_a;
         tr_b[n] = cmp_b;
         n++;
         @(negedge clk);
      end
      chk("sort_len", n, exp_cyc);
      chk("sort_cycles", sort_cycles, exp_cyc);
      chk("first_out_valid", out_valid, 1);
   endtask

   task automatic drain(input logic [0:3][7:0] exp, input logic [0:6] pat);
      int   n = 0;
      int   k = 0;
      logic stalled = 1'b0;
      logic [7:0] held = 8'd0;
      while (n < 4 && k < 60) begin
         if (stalled) chk("stall_hold", out_data, held);
         chk("drain_in_ready", in_ready, 0);
         out_ready = pat[k % 7];
         if (out_valid && out_ready) begin
            chk("out_data", out_data, exp[n]);
            n++;
            stalled = 1'b0;
         end else begin
            stalled = out_valid;
            held    = out_data;
         end
         k++;
         @(negedge clk);
      end
      chk("xfer_count", n, 4);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("post_in_ready", in_ready, 1);
      chk("post_out_valid", out_valid, 0);
      chk("post_sort_cycles_held", sort_cycles, exp[0] == 8'd0 ? 6 : sort_cycles);
   endtask

   vec_t vecs [4];
   int   exp_a [6] = '{30, 20, 10, 20, 10, 10};
   int   exp_b [6] = '{40, 40, 40, 30, 30, 20};

   initial begin
      vecs[0] = '{din: {8'd10, 8'd20, 8'd30, 8'd40}, dout: {8'd10, 8'd20, 8'd30, 8'd40}, cyc: 3};
      vecs[1] = '{din: {8'd40, 8'd30, 8'd20, 8'd10}, dout: {8'd10, 8'd20, 8'd30, 8'd40}, cyc: 6};
      vecs[2] = '{din: {8'd7, 8'd7, 8'd3, 8'd7}, dout: {8'd3, 8'd7, 8'd7, 8'd7}, cyc: 6};
      vecs[3] = '{din: {8'd255, 8'd0, 8'd128, 8'd1}, dout: {8'd0, 8'd1, 8'd128, 8'd255}, cyc: 6};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'd0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_cmp_a", cmp_a, 0);
      chk("rst_cmp_b", cmp_b, 0);
      chk("rst_sort_cycles", sort_cycles, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         load(vecs[i].din, 1'b0);
         run_sort(vecs[i].cyc);
         drain(vecs[i].dout, 7'b1111111);
      end

      // Reverse batch: compare order trace and stalled drain.
      load(vecs[1].din, 1'b0);
      run_sort(6);
      for (int i = 0; i < 6; i++) begin
         chk("trace_cmp_a", tr_a[i], exp_a[i]);
         chk("trace_cmp_b", tr_b[i], exp_b[i]);
      end
      drain(vecs[1].dout, 7'b1001101);
      chk("hold_sort_cycles_in_load", sort_cycles, 6);

      // Reset in SORT cycle 2 aborts the batch.
      load(vecs[1].din, 1'b0);
      @(negedge clk);
      chk("abort_out_valid_c2", out_valid, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_cmp_a", cmp_a, 0);
      chk("abort_sort_cycles", sort_cycles, 0);
      load({8'd1, 8'd2, 8'd3, 8'd4}, 1'b0);
      run_sort(3);
      drain({8'd1, 8'd2, 8'd3, 8'd4}, 7'b1111111);

      // in_valid held with 99 through SORT and DRAIN is ignored.
      load(vecs[3].din, 1'b1);
      run_sort(6);
      drain(vecs[3].dout, 7'b1111111);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
